hazard_unit_mc: RTL

//  Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W), successor of the single-cycle hazard block.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/div_stall_ctr.sv | 88 ++++++++
 rtl/hazard_unit_mc.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller: load marker,
// forwarding select codes and the divider-stall FSM state type.
package hazard_pkg;

  // memtoreg value that marks a load instruction
  localparam logic [1:0] LOAD_ENC = 2'b01;

  // E-stage forwarding selects
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b10;
  localparam logic [1:0] FWD_W    = 2'b01;

  // Divider stall FSM
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } divState_t;

endpackage

// File: rtl/div_stall_ctr.sv
// Divider stall sequencer. A div entering E while IDLE stalls immediately,
// then stays BUSY for DIV_CYCLES cycles, then spends one DONE cycle in which
// the result is valid and E is allowed to advance. DONE always returns to
// IDLE so the same div cannot retrigger itself. abort (exception) forces IDLE.
module div_stall_ctr
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      divE,
  input  logic      abort,
  output logic      stallDiv,
  output logic      divBusy,
  output logic      divDone,
  output divState_t dbgState
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

  divState_t     state;
  divState_t     stateNext;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;

  // State and counter registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Next-state and counter update; abort wins over normal sequencing
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (abort) begin
      stateNext = DIV_IDLE;
      cntNext   = '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (divE) begin
            stateNext = DIV_BUSY;
            cntNext   = CNT_LOAD;
          end
        end
        DIV_BUSY: begin
          if (cnt == '0) stateNext = DIV_DONE;
          else           cntNext   = cnt - 1'b1;
        end
        DIV_DONE: stateNext = DIV_IDLE;
        default: begin
          stateNext = DIV_IDLE;
          cntNext   = '0;
        end
      endcase
    end
  end

  // Outputs: the first stall cycle comes straight from divE while IDLE
  always_comb begin
    stallDiv = 1'b0;
    divBusy  = 1'b0;
    divDone  = 1'b0;
    case (state)
      DIV_IDLE: stallDiv = divE;
      DIV_BUSY: begin
        stallDiv = 1'b1;
        divBusy  = 1'b1;
      end
      DIV_DONE: begin
        divBusy = 1'b1;
        divDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbgState = state;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use and branch-compare stalls, divider stalls and the stall/flush
// priority between exception, divider, data hazards and mispredicts.
module hazard_unit_mc #(
  parameter int         REG_AW     = 5,
  parameter int         DIV_CYCLES = 32,
  parameter logic [1:0] LOAD_ENC   = hazard_pkg::LOAD_ENC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_AW-1:0]     rsD,
  input  logic [REG_AW-1:0]     rtD,
  input  logic                  branchD,
  input  logic [REG_AW-1:0]     rsE,
  input  logic [REG_AW-1:0]     rtE,
  input  logic [REG_AW-1:0]     writeregE,
  input  logic                  regwriteE,
  input  logic [1:0]            memtoregE,
  input  logic                  divE,
  input  logic                  predict_wrongE,
  input  logic [REG_AW-1:0]     writeregM,
  input  logic                  regwriteM,
  input  logic [1:0]            memtoregM,
  input  logic                  exceptM,
  input  logic [REG_AW-1:0]     writeregW,
  input  logic                  regwriteW,
  output logic                  forwardaD,
  output logic                  forwardbD,
  output logic [1:0]            forwardaE,
  output logic [1:0]            forwardbE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  stallE,
  output logic                  stallM,
  output logic                  stallW,
  output logic                  flushF,
  output logic                  flushD,
  output logic                  flushE,
  output logic                  flushM,
  output logic                  flushW,
  output logic                  div_busy,
  output logic                  div_done,
  output hazard_pkg::divState_t dbgDivState
);

  import hazard_pkg::*;

  logic lwStall;
  logic brStall;
  logic stallDiv;

  // E-stage forwarding: M result has priority over W; register 0 never forwards
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    if (src != '0 && regwriteM && writeregM == src)      return FWD_M;
    else if (src != '0 && regwriteW && writeregW == src) return FWD_W;
    else                                                 return FWD_NONE;
  endfunction

  assign forwardaE = fwdSel(rsE);
  assign forwardbE = fwdSel(rtE);

  // D-stage compare operands may only take an ALU result (not a load) from M
  assign forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD) && (memtoregM != LOAD_ENC);
  assign forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD) && (memtoregM != LOAD_ENC);

  // Load in E whose target is read by the instruction in D
  assign lwStall = (memtoregE == LOAD_ENC) && (rtE != '0) && ((rtE == rsD) || (rtE == rtD));

  // Branch compare in D needs a value not yet available (ALU in E, load in M)
  assign brStall = branchD &&
                   ((regwriteE && (writeregE != '0) && ((writeregE == rsD) || (writeregE == rtD))) ||
                    ((memtoregM == LOAD_ENC) && ((writeregM == rsD) || (writeregM == rtD))));

  div_stall_ctr #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_stall_ctr (
    .clk      (clk),
    .rst      (rst),
    .divE     (divE),
    .abort    (exceptM),
    .stallDiv (stallDiv),
    .divBusy  (div_busy),
    .divDone  (div_done),
    .dbgState (dbgDivState)
  );

  // Stall/flush priority: exception > divider > data hazards, mispredict last
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    flushW = 1'b0;
    if (exceptM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
      flushW = 1'b1;
    end else if (stallDiv) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else begin
      if (lwStall || brStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
      if (predict_wrongE) begin
        flushD = 1'b1;
        stallD = 1'b0;
      end
    end
  end

  assign flushF = 1'b0;
  assign stallM = 1'b0;
  assign stallW = 1'b0;

endmodule
